// File: rtl/booth_pe_pkg.sv
// Shared definitions for the Booth PE scratchpad row logic.
//   - drain_state_e : tile sequencer states
//   - DEFAULT_DEPTH : words per tile, equal to the SPad 9-slot pointer wrap
//   - SPAD_DATA_WIDTH : SPad word width derived from the array size
package booth_pe_pkg;

  localparam int MATRIX_SIZE     = 3;
  // Worst-case accumulation range of a 3x3 tile: $clog2(768) - 1 = 9 bits.
  localparam int SPAD_DATA_WIDTH = $clog2(MATRIX_SIZE * 256) - 1;
  localparam int DEFAULT_DEPTH   = 9;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    DRAIN,
    FLUSH,
    DONE
  } drain_state_e;

endpackage

// File: rtl/spad_skid_buf.sv
// Two-entry FIFO between the tail SPad read port and the result collector.
// Entries are held in a head/tail register pair, so the head (the
// output word) always comes straight from a flop.
//   clk, reset_n   : clock, async active-low reset
//   flush          : drop all entries
//   push/push_data : write one entry (caller guarantees space)
//   pop            : consume the head (caller guarantees head_valid)
//   head_valid/head_data : oldest entry
//   occupancy      : number of valid entries, 0..2
module spad_skid_buf #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         head_valid,
  output logic [W-1:0] head_data,
  output logic [1:0]   occupancy
);

  logic         tail_valid;
  logic [W-1:0] tail_data;

  assign occupancy = {1'b0, head_valid} + {1'b0, tail_valid};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_valid <= 1'b0;
      tail_valid <= 1'b0;
      head_data  <= '0;
      tail_data  <= '0;
    end else if (flush) begin
      head_valid <= 1'b0;
      tail_valid <= 1'b0;
      head_data  <= '0;
      tail_data  <= '0;
    end else if (pop) begin
      if (tail_valid) begin
        // Tail advances to head; a concurrent push refills the tail.
        head_data  <= tail_data;
        tail_valid <= push;
        if (push) tail_data <= push_data;
      end else begin
        head_valid <= push;
        if (push) head_data <= push_data;
      end
    end else if (push) begin
      if (!head_valid) begin
        head_valid <= 1'b1;
        head_data  <= push_data;
      end else if (!tail_valid) begin
        tail_valid <= 1'b1;
        tail_data  <= push_data;
      end
    end
  end

endmodule

// File: rtl/spad_drain_ctrl.sv
// Per-row tile sequencer for the Booth PE scratchpad chain: clears the
// row's SPads, waits for acc_beats tail write beats, then drains DEPTH
// words through a 2-entry buffer with a valid/ready handshake.
//   start/abort/acc_beats       : tile control
//   spad_w_valid                : tail SPad write beat
//   spad_read_ready/spad_r_data : tail SPad read side (data 1 cycle after req)
//   spad_inner_reset            : one-cycle clear to all row SPads
//   spad_read_req               : read strobe to the tail SPad
//   out_valid/out_ready/out_data/out_last : result stream
//   busy/done/err_timeout       : status
module spad_drain_ctrl
  import booth_pe_pkg::*;
#(
  parameter int DATA_WIDTH = SPAD_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int BEAT_W     = 16,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [BEAT_W-1:0]     acc_beats,
  input  logic                  spad_w_valid,
  input  logic                  spad_read_ready,
  input  logic [DATA_WIDTH-1:0] spad_r_data,
  output logic                  spad_inner_reset,
  output logic                  spad_read_req,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err_timeout
);

  localparam int IDX_W = $clog2(DEPTH + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] DEPTH_L  = IDX_W'(DEPTH);
  localparam logic [IDX_W-1:0] DEPTH_M1 = IDX_W'(DEPTH - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  drain_state_e      state;
  logic [BEAT_W-1:0] acc_beats_q;
  logic [BEAT_W-1:0] beat_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [IDX_W-1:0]  rd_issued;
  logic              infl;       // read issued last cycle, data on spad_r_data now
  logic              infl_last;  // that read was drain index DEPTH-1
  logic [1:0]        occ;
  logic              pop;
  logic              kill;
  logic              credit_ok;

  assign kill = abort && (state != IDLE);
  assign pop  = out_valid && out_ready;

  // SPad data cannot be stalled, so a read is only issued when the buffer
  // is guaranteed a free slot when its data lands. This cycle's pop is
  // counted so the 2-entry buffer sustains one word per cycle at full rate.
  assign credit_ok     = (int'(occ) + int'(infl) - int'(pop)) < 2;
  assign spad_read_req = (state == DRAIN) && !abort && (rd_issued < DEPTH_L) && credit_ok;

  spad_skid_buf #(.W(DATA_WIDTH + 1)) u_buf (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (kill),
    .push       (infl),
    .push_data  ({infl_last, spad_r_data}),
    .pop        (pop),
    .head_valid (out_valid),
    .head_data  ({out_last, out_data}),
    .occupancy  (occ)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      acc_beats_q      <= '0;
      beat_cnt         <= '0;
      tmo_cnt          <= '0;
      rd_issued        <= '0;
      infl             <= 1'b0;
      infl_last        <= 1'b0;
      spad_inner_reset <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err_timeout      <= 1'b0;
    end else begin
      spad_inner_reset <= 1'b0;
      done             <= 1'b0;
      infl             <= spad_read_req;
      infl_last        <= (rd_issued == DEPTH_M1);
      if (spad_read_req) rd_issued <= rd_issued + 1'b1;

      if (kill) begin
        // Abort wins over everything; in-flight data is dropped.
        state            <= IDLE;
        busy             <= 1'b0;
        spad_inner_reset <= 1'b1;
        infl             <= 1'b0;
      end else begin
        unique case (state)
          IDLE: if (start) begin
            state            <= CLEAR;
            busy             <= 1'b1;
            spad_inner_reset <= 1'b1;
            acc_beats_q      <= acc_beats;
            err_timeout      <= 1'b0;
            beat_cnt         <= '0;
            tmo_cnt          <= '0;
            rd_issued        <= '0;
          end
          CLEAR: begin
            if (acc_beats_q == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
          ACCUM: begin
            if (spad_w_valid && (beat_cnt != acc_beats_q)) beat_cnt <= beat_cnt + 1'b1;
            tmo_cnt <= tmo_cnt + 1'b1;
            // Completion beats a simultaneous timeout.
            if ((beat_cnt == acc_beats_q) && spad_read_ready) begin
              state <= DRAIN;
            end else if (tmo_cnt == TMO_LAST) begin
              state            <= IDLE;
              busy             <= 1'b0;
              err_timeout      <= 1'b1;
              spad_inner_reset <= 1'b1;
            end
          end
          DRAIN: if (spad_read_req && (rd_issued == DEPTH_M1)) state <= FLUSH;
          FLUSH: begin
            // Buffer empties on this edge (last word popped, nothing landing).
            if ((int'(occ) + int'(infl) - int'(pop)) == 0) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spad_drain_ctrl.sv
// Directed bench for spad_drain_ctrl with a tail-SPad read model returning
// 1..9 per tile and a monitor that records handshakes, reads and pulses.
module tb_spad_drain_ctrl;

  localparam int DW    = 9;
  localparam int DEPTH = 9;
  localparam int BW    = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [BW-1:0] acc_beats = '0;
  logic          spad_w_valid = 1'b0;
  logic          spad_read_ready = 1'b0;
  logic [DW-1:0] spad_r_data;
  logic          out_ready = 1'b0;
  logic          spad_inner_reset, spad_read_req, out_valid, out_last, busy, done, err_timeout;
  logic [DW-1:0] out_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cnt, rd_run, rd_run_max, first_rd_cyc, done_cnt, done_cyc, last_hs_cyc;
  int credit_viol, outstanding, inner_cnt;
  logic [DW:0] got_q[$];
  logic [3:0]  ptr;
  int t0;

  spad_drain_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .BEAT_W(BW), .TIMEOUT(16)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .abort            (abort),
    .acc_beats        (acc_beats),
    .spad_w_valid     (spad_w_valid),
    .spad_read_ready  (spad_read_ready),
    .spad_r_data      (spad_r_data),
    .spad_inner_reset (spad_inner_reset),
    .spad_read_req    (spad_read_req),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_last         (out_last),
    .busy             (busy),
    .done             (done),
    .err_timeout      (err_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Tail SPad: registered read data, pointer cleared by inner reset.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= 4'd0;
      spad_r_data <= '0;
    end else if (spad_inner_reset) begin
      ptr <= 4'd0;
    end else if (spad_read_req) begin
      spad_r_data <= {5'b0, ptr + 4'd1};
      ptr <= (ptr == 4'd8) ? 4'd0 : ptr + 4'd1;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (spad_read_req) begin
        if (rd_cnt == 0) first_rd_cyc = cyc;
        rd_cnt++;
        rd_run++;
        if (rd_run > rd_run_max) rd_run_max = rd_run;
      end else begin
        rd_run = 0;
      end
      outstanding += int'(spad_read_req) - int'(out_valid && out_ready);
      if (outstanding > 2) credit_viol++;
      if (out_valid && out_ready) begin
        got_q.push_back({out_last, out_data});
        last_hs_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (spad_inner_reset) inner_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_mon();
    rd_cnt = 0; rd_run = 0; rd_run_max = 0; first_rd_cyc = 0;
    done_cnt = 0; done_cyc = 0; last_hs_cyc = 0;
    credit_viol = 0; outstanding = 0; inner_cnt = 0;
    got_q.delete();
  endtask

  // Cycles 0..11: start, CLEAR, nine beats at cycles 2..10, read_ready from
  // cycle 5, and an ignored start (with acc_beats=0) at cycle 6.
  task automatic begin_tile(output int t_start);
    step();
    clear_mon();
    t_start = cyc;
    start = 1'b1; acc_beats = BW'(9); out_ready = 1'b1; spad_read_ready = 1'b0;
    mid();
    step();
    start = 1'b0;
    mid();
    chk("clear_pulse", 32'(spad_inner_reset), 32'd1);
    chk("clear_busy", 32'(busy), 32'd1);
    chk("err_cleared_by_start", 32'(err_timeout), 32'd0);
    for (int k = 2; k <= 10; k++) begin
      step();
      spad_w_valid = 1'b1;
      spad_read_ready = (k >= 5);
      start = (k == 6);
      acc_beats = (k == 6) ? BW'(0) : BW'(9);
      mid();
      if (k == 2) chk("accum_entry", 32'({spad_inner_reset, busy}), 32'b01);
    end
    step();
    spad_w_valid = 1'b0; start = 1'b0; acc_beats = BW'(9);
    mid();
  endtask

  task automatic finish_tile(input bit alt, input bit exact, input int t_start);
    for (int n = 0; n < 80 && done_cnt == 0; n++) begin
      step();
      if (alt) out_ready = ~out_ready;
      mid();
    end
    chk("done_seen", 32'(done_cnt), 32'd1);
    chk("word_count", 32'(got_q.size()), 32'd9);
    for (int i = 0; i < got_q.size() && i < 9; i++)
      chk($sformatf("word%0d", i), 32'(got_q[i]), 32'({(i == 8), DW'(i + 1)}));
    chk("read_count", 32'(rd_cnt), 32'd9);
    chk("credit", 32'(credit_viol), 32'd0);
    chk("done_after_last", 32'(done_cyc - last_hs_cyc), 32'd1);
    if (exact) begin
      chk("first_read_cyc", 32'(first_rd_cyc - t_start), 32'd12);
      chk("read_run", 32'(rd_run_max), 32'd9);
      chk("done_cyc", 32'(done_cyc - t_start), 32'd23);
    end
    step();
    out_ready = 1'b1;
    mid();
    chk("idle_after_done", 32'({busy, done}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_mon();
    // Reset with random inputs.
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom); abort = 1'($urandom); acc_beats = BW'($urandom);
      spad_w_valid = 1'($urandom); spad_read_ready = 1'($urandom); out_ready = 1'($urandom);
      mid();
      chk("reset_outputs", 32'({spad_inner_reset, spad_read_req, out_valid, out_data,
                                out_last, busy, done, err_timeout}), 32'd0);
      step();
    end
    start = 1'b0; abort = 1'b0; acc_beats = '0; spad_w_valid = 1'b0;
    spad_read_ready = 1'b0; out_ready = 1'b0;
    step();
    reset_n = 1'b1;
    mid();
    chk("busy_after_reset", 32'(busy), 32'd0);

    // Basic tile at full rate, exact timing.
    begin_tile(t0);
    finish_tile(1'b0, 1'b1, t0);

    // Backpressure: out_ready alternates.
    begin_tile(t0);
    finish_tile(1'b1, 1'b0, t0);

    // Timeout: ACCUM cycles 2..17, error visible at cycle 18.
    step();
    clear_mon();
    start = 1'b1; acc_beats = BW'(5); spad_read_ready = 1'b0; spad_w_valid = 1'b0;
    mid();
    step();
    start = 1'b0;
    mid();
    for (int k = 2; k <= 17; k++) begin
      step();
      mid();
      if (k == 17) chk("tmo_not_yet", 32'({err_timeout, busy}), 32'b01);
    end
    step();
    mid();
    chk("tmo_err", 32'(err_timeout), 32'd1);
    chk("tmo_inner_reset", 32'(spad_inner_reset), 32'd1);
    chk("tmo_idle", 32'(busy), 32'd0);
    step();
    mid();
    chk("tmo_after", 32'({spad_inner_reset, err_timeout}), 32'b01);
    chk("tmo_no_done", 32'(done_cnt), 32'd0);
    chk("tmo_inner_pulses", 32'(inner_cnt), 32'd2);

    // Abort after word 4 is accepted (word 4 at cycle 17, abort at 18).
    begin_tile(t0);
    for (int n = 0; n < 40 && got_q.size() < 4; n++) begin
      step();
      mid();
    end
    chk("abort_wait_words", 32'(got_q.size()), 32'd4);
    step();
    abort = 1'b1; out_ready = 1'b0;
    mid();
    step();
    abort = 1'b0;
    mid();
    chk("abort_inner_reset", 32'(spad_inner_reset), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_no_read", 32'(spad_read_req), 32'd0);
    step();
    mid();
    chk("abort_idle", 32'({busy, spad_inner_reset, out_valid}), 32'd0);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    for (int i = 0; i < got_q.size() && i < 4; i++)
      chk($sformatf("abort_word%0d", i), 32'(got_q[i]), 32'(i + 1));

    // Clean tile after abort.
    begin_tile(t0);
    finish_tile(1'b0, 1'b1, t0);

    // acc_beats = 0: done at cycle 2, no reads.
    step();
    clear_mon();
    start = 1'b1; acc_beats = BW'(0);
    mid();
    step();
    start = 1'b0;
    mid();
    chk("zero_clear", 32'({spad_inner_reset, done}), 32'b10);
    step();
    mid();
    chk("zero_done", 32'(done), 32'd1);
    step();
    mid();
    chk("zero_idle", 32'({busy, done}), 32'd0);
    chk("zero_reads", 32'(rd_cnt + got_q.size()), 32'd0);

    // Asynchronous reset in the middle of DRAIN.
    begin_tile(t0);
    for (int n = 0; n < 40 && got_q.size() < 2; n++) begin
      step();
      mid();
    end
    chk("pre_reset_busy", 32'({busy, out_valid}), 32'b11);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({spad_inner_reset, spad_read_req, out_valid, out_data,
                                    out_last, busy, done, err_timeout}), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    mid();
    chk("post_reset_idle", 32'({busy, out_valid, spad_inner_reset}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
